wordle_entry: RTL and testbench

WORDLE_ENTRY -- requirements
Module: wordle_entry

---
 rtl/wordle_pkg.sv | 36 +++
 rtl/wordle_entry_if.sv | 28 ++
 rtl/wordle_entry_letter_sel.sv | 42 ++++
 rtl/wordle_entry.sv | 114 +++++++++++
 tb/tb_wordle_entry.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wordle_pkg.sv
// Shared constants, state encoding and guess-buffer slot helpers for the Wordle letter-entry block.
package wordle_pkg;

  localparam int unsigned GUESS_LEN = 5;
  localparam int unsigned CHAR_W    = 8;
  localparam int unsigned GUESS_W   = GUESS_LEN * CHAR_W;
  localparam int unsigned CUR_W     = 3;

  localparam logic [CHAR_W-1:0] ASCII_A     = 8'h41;
  localparam logic [CHAR_W-1:0] ASCII_Z     = 8'h5A;
  localparam logic [CHAR_W-1:0] ASCII_SPACE = 8'h20;

  typedef enum logic [1:0] {
    QENTRY = 2'b01,
    QSEND  = 2'b10
  } state_e;

  // Slot 0 lives in the top byte of the buffer.
  function automatic logic [CHAR_W-1:0] slot_get(input logic [GUESS_W-1:0] g,
                                                 input logic [CUR_W-1:0]   idx);
    slot_get = ASCII_SPACE;
    for (int i = 0; i < int'(GUESS_LEN); i++) begin
      if (idx == CUR_W'(i)) slot_get = g[GUESS_W-1-CHAR_W*i -: CHAR_W];
    end
  endfunction

  function automatic logic [GUESS_W-1:0] slot_set(input logic [GUESS_W-1:0] g,
                                                  input logic [CUR_W-1:0]   idx,
                                                  input logic [CHAR_W-1:0]  ch);
    slot_set = g;
    for (int i = 0; i < int'(GUESS_LEN); i++) begin
      if (idx == CUR_W'(i)) slot_set[GUESS_W-1-CHAR_W*i -: CHAR_W] = ch;
    end
  endfunction

endpackage

// File: rtl/wordle_entry_if.sv
// Button/letter-stream bundle between the game and wordle_entry; master is the entry block.
interface wordle_entry_if;
  import wordle_pkg::*;

  logic                BtnU;
  logic                BtnD;
  logic                BtnL;
  logic                BtnR;
  logic                BtnC;
  logic                enable;
  logic                letter_ready;
  logic [CHAR_W-1:0]   curr_letter;
  logic                letter_valid;
  logic                last_letter;
  logic [CHAR_W-1:0]   sel_letter;
  logic [CUR_W-1:0]    cursor;
  logic [GUESS_W-1:0]  guess_buf;

  modport master (
    input  BtnU, BtnD, BtnL, BtnR, BtnC, enable, letter_ready,
    output curr_letter, letter_valid, last_letter, sel_letter, cursor, guess_buf
  );

  modport slave (
    output BtnU, BtnD, BtnL, BtnR, BtnC, enable, letter_ready,
    input  curr_letter, letter_valid, last_letter, sel_letter, cursor, guess_buf
  );
endinterface

// File: rtl/wordle_entry_letter_sel.sv
// Letter selector register 'A'..'Z'. End-of-range wraps when WORDLE_ENTRY_WRAP_EN is defined,
// otherwise saturates.
module letter_sel
  import wordle_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              up_i,
  input  logic              down_i,
  input  logic              clr_i,
  output logic [CHAR_W-1:0] sel_o
);

`ifdef WORDLE_ENTRY_WRAP_EN
  localparam logic [CHAR_W-1:0] AFTER_Z  = ASCII_A;
  localparam logic [CHAR_W-1:0] BEFORE_A = ASCII_Z;
`else
  localparam logic [CHAR_W-1:0] AFTER_Z  = ASCII_Z;
  localparam logic [CHAR_W-1:0] BEFORE_A = ASCII_A;
`endif

  logic [CHAR_W-1:0] sel_q, sel_d;

  always_comb begin
    sel_d = sel_q;
    if (clr_i) begin
      sel_d = ASCII_A;
    end else if (up_i) begin
      sel_d = (sel_q == ASCII_Z) ? AFTER_Z : sel_q + 8'd1;
    end else if (down_i) begin
      sel_d = (sel_q == ASCII_A) ? BEFORE_A : sel_q - 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sel_q <= ASCII_A;
    else       sel_q <= sel_d;
  end

  assign sel_o = sel_q;

endmodule

// File: rtl/wordle_entry.sv
// Wordle guess entry: edits a five-letter buffer from buttons, then streams it to the game
// over a valid/ready handshake. Build option: WORDLE_ENTRY_WRAP_EN (letter wrap vs saturate).
module wordle_entry
  import wordle_pkg::*;
(
  input  logic          Clk,
  input  logic          reset,
  wordle_entry_if.master bus
);

  state_e              state_q, state_d;
  logic [CUR_W-1:0]    cursor_q, cursor_d;
  logic [CUR_W-1:0]    idx_q, idx_d;
  logic [GUESS_W-1:0]  guess_q, guess_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic [CHAR_W-1:0]   curr_q, curr_d;
  logic [CHAR_W-1:0]   sel;
  logic                sel_up, sel_dn, sel_clr;

  letter_sel u_letter_sel (
    .clk_i  (Clk),
    .rst_i  (reset),
    .up_i   (sel_up),
    .down_i (sel_dn),
    .clr_i  (sel_clr),
    .sel_o  (sel)
  );

  // Only the highest-priority pressed button is considered each cycle.
  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    idx_d    = idx_q;
    guess_d  = guess_q;
    sel_up   = 1'b0;
    sel_dn   = 1'b0;
    sel_clr  = 1'b0;
    unique case (state_q)
      QENTRY: begin
        if (bus.enable) begin
          if (bus.BtnC) begin
            if (cursor_q == CUR_W'(GUESS_LEN)) begin
              state_d = QSEND;
              idx_d   = '0;
            end
          end else if (bus.BtnL) begin
            if (cursor_q != '0) begin
              cursor_d = cursor_q - 3'd1;
              guess_d  = slot_set(guess_q, cursor_q - 3'd1, ASCII_SPACE);
            end
          end else if (bus.BtnR) begin
            if (cursor_q < CUR_W'(GUESS_LEN)) begin
              guess_d  = slot_set(guess_q, cursor_q, sel);
              cursor_d = cursor_q + 3'd1;
              sel_clr  = 1'b1;
            end
          end else if (bus.BtnU) begin
            sel_up = 1'b1;
          end else if (bus.BtnD) begin
            sel_dn = 1'b1;
          end
        end
      end
      QSEND: begin
        if (valid_q && bus.letter_ready) begin
          if (idx_q == CUR_W'(GUESS_LEN - 1)) begin
            state_d  = QENTRY;
            cursor_d = '0;
            idx_d    = '0;
            guess_d  = {GUESS_LEN{ASCII_SPACE}};
            sel_clr  = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = QENTRY;
    endcase

    // Outputs are registered copies of what the next state implies.
    valid_d = (state_d == QSEND);
    curr_d  = valid_d ? slot_get(guess_d, idx_d) : ASCII_SPACE;
    last_d  = valid_d && (idx_d == CUR_W'(GUESS_LEN - 1));
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q  <= QENTRY;
      cursor_q <= '0;
      idx_q    <= '0;
      guess_q  <= {GUESS_LEN{ASCII_SPACE}};
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      curr_q   <= ASCII_SPACE;
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      idx_q    <= idx_d;
      guess_q  <= guess_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      curr_q   <= curr_d;
    end
  end

  assign bus.curr_letter  = curr_q;
  assign bus.letter_valid = valid_q;
  assign bus.last_letter  = last_q;
  assign bus.sel_letter   = sel;
  assign bus.cursor       = cursor_q;
  assign bus.guess_buf    = guess_q;

endmodule

// File: tb/tb_wordle_entry.sv
// Directed self-checking bench for wordle_entry; expectations follow WORDLE_ENTRY_WRAP_EN.
module tb_wordle_entry;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  wordle_entry_if bus();

  wordle_entry dut (
    .Clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [39:0] ALL_SP = {5{8'h20}};

  function automatic logic [39:0] pack(input string s);
    logic [39:0] r;
    r = ALL_SP;
    for (int i = 0; i < 5; i++) begin
      if (i < s.len()) r[39-8*i -: 8] = s[i];
    end
    return r;
  endfunction

  task automatic pulse(input logic u, input logic d, input logic l, input logic r, input logic c);
    bus.BtnU = u; bus.BtnD = d; bus.BtnL = l; bus.BtnR = r; bus.BtnC = c;
    @(negedge clk);
    bus.BtnU = 1'b0; bus.BtnD = 1'b0; bus.BtnL = 1'b0; bus.BtnR = 1'b0; bus.BtnC = 1'b0;
  endtask

  task automatic enter_letter(input byte ch);
    for (int k = 0; k < int'(ch) - 65; k++) pulse(1, 0, 0, 0, 0);
    pulse(0, 0, 0, 1, 0);
  endtask

  task automatic enter_word(input string w);
    for (int i = 0; i < w.len(); i++) enter_letter(w[i]);
  endtask

  task automatic do_reset();
    bus.letter_ready = 1'b0;
    bus.enable = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (bus.letter_valid !== 1'b0 || bus.last_letter !== 1'b0 || bus.curr_letter !== 8'h20) begin
      n_err++;
      $display("FAIL reset_stream: valid=%b last=%b curr=%h expected 0 0 20",
               bus.letter_valid, bus.last_letter, bus.curr_letter);
    end
    n_vec++;
    if (bus.sel_letter !== 8'h41 || bus.cursor !== 3'd0 || bus.guess_buf !== ALL_SP) begin
      n_err++;
      $display("FAIL reset_entry: sel=%h cursor=%0d buf=%h expected 41 0 %h",
               bus.sel_letter, bus.cursor, bus.guess_buf, ALL_SP);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_select();
    do_reset();
    pulse(1, 0, 0, 0, 0); pulse(1, 0, 0, 0, 0); pulse(1, 0, 0, 0, 0);
    n_vec++;
    if (bus.sel_letter !== 8'h44) begin
      n_err++; $display("FAIL sel_up3: sel=%h expected 44", bus.sel_letter);
    end
    bus.enable = 1'b0;
    pulse(1, 0, 0, 1, 0);
    bus.enable = 1'b1;
    n_vec++;
    if (bus.sel_letter !== 8'h44 || bus.cursor !== 3'd0) begin
      n_err++; $display("FAIL enable_gate: sel=%h cursor=%0d expected 44 0", bus.sel_letter, bus.cursor);
    end
    pulse(0, 0, 0, 1, 0);
    n_vec++;
    if (bus.guess_buf !== pack("D") || bus.cursor !== 3'd1 || bus.sel_letter !== 8'h41) begin
      n_err++;
      $display("FAIL accept_d: buf=%h cursor=%0d sel=%h expected %h 1 41",
               bus.guess_buf, bus.cursor, bus.sel_letter, pack("D"));
    end
  endtask

  task automatic test_stream_ready();
    string w;
    w = "ROBOT";
    do_reset();
    enter_word(w);
    bus.letter_ready = 1'b1;
    pulse(0, 0, 0, 0, 1);
    bus.enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (bus.letter_valid !== 1'b1 || bus.curr_letter !== 8'(w[i]) || bus.last_letter !== (i == 4)) begin
        n_err++;
        $display("FAIL stream_b2b[%0d]: valid=%b curr=%h last=%b expected 1 %h %b",
                 i, bus.letter_valid, bus.curr_letter, bus.last_letter, 8'(w[i]), (i == 4));
      end
      @(negedge clk);
    end
    n_vec++;
    if (bus.letter_valid !== 1'b0 || bus.curr_letter !== 8'h20 || bus.cursor !== 3'd0 ||
        bus.guess_buf !== ALL_SP || bus.sel_letter !== 8'h41 || bus.last_letter !== 1'b0) begin
      n_err++;
      $display("FAIL stream_done: valid=%b curr=%h cursor=%0d buf=%h sel=%h expected 0 20 0 %h 41",
               bus.letter_valid, bus.curr_letter, bus.cursor, bus.guess_buf, bus.sel_letter, ALL_SP);
    end
    bus.enable = 1'b1;
    bus.letter_ready = 1'b0;
  endtask

  task automatic test_stream_toggle();
    string w;
    int    n;
    int    k;
    w = "ROBOT";
    n = 0;
    k = 0;
    do_reset();
    enter_word(w);
    pulse(0, 0, 0, 0, 1);
    while (n < 5 && k < 40) begin
      bus.letter_ready = (k % 3 == 0);
      n_vec++;
      if (bus.letter_valid !== 1'b1 || bus.curr_letter !== 8'(w[n]) || bus.last_letter !== (n == 4)) begin
        n_err++;
        $display("FAIL stream_toggle[%0d]: valid=%b curr=%h last=%b expected 1 %h %b",
                 k, bus.letter_valid, bus.curr_letter, bus.last_letter, 8'(w[n]), (n == 4));
      end
      if (bus.letter_ready) n++;
      k++;
      @(negedge clk);
    end
    bus.letter_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      n_vec++;
      if (bus.letter_valid !== 1'b0 || n !== 5) begin
        n_err++;
        $display("FAIL stream_toggle_end[%0d]: valid=%b transfers=%0d expected 0 5", j, bus.letter_valid, n);
      end
      @(negedge clk);
    end
    bus.letter_ready = 1'b0;
  endtask

  task automatic test_edges();
    do_reset();
    pulse(0, 0, 1, 0, 0);
    n_vec++;
    if (bus.cursor !== 3'd0 || bus.guess_buf !== ALL_SP) begin
      n_err++; $display("FAIL del_at_0: cursor=%0d buf=%h expected 0 %h", bus.cursor, bus.guess_buf, ALL_SP);
    end
    enter_word("ABCD");
    pulse(0, 0, 0, 0, 1);
    n_vec++;
    if (bus.cursor !== 3'd4 || bus.letter_valid !== 1'b0 || bus.guess_buf !== pack("ABCD")) begin
      n_err++;
      $display("FAIL submit_at_4: cursor=%0d valid=%b buf=%h expected 4 0 %h",
               bus.cursor, bus.letter_valid, bus.guess_buf, pack("ABCD"));
    end
    pulse(0, 0, 1, 0, 0);
    n_vec++;
    if (bus.cursor !== 3'd3 || bus.guess_buf !== pack("ABC")) begin
      n_err++;
      $display("FAIL del_at_4: cursor=%0d buf=%h expected 3 %h", bus.cursor, bus.guess_buf, pack("ABC"));
    end
    enter_word("XY");
    pulse(1, 0, 0, 0, 0);
    pulse(0, 0, 0, 1, 0);
    n_vec++;
    if (bus.cursor !== 3'd5 || bus.guess_buf !== pack("ABCXY") || bus.sel_letter !== 8'h42) begin
      n_err++;
      $display("FAIL accept_at_5: cursor=%0d buf=%h sel=%h expected 5 %h 42",
               bus.cursor, bus.guess_buf, bus.sel_letter, pack("ABCXY"));
    end
    pulse(0, 0, 0, 1, 1);
    n_vec++;
    if (bus.letter_valid !== 1'b1 || bus.curr_letter !== 8'h41 || bus.cursor !== 3'd5 ||
        bus.guess_buf !== pack("ABCXY")) begin
      n_err++;
      $display("FAIL submit_and_accept: valid=%b curr=%h cursor=%0d buf=%h expected 1 41 5 %h",
               bus.letter_valid, bus.curr_letter, bus.cursor, bus.guess_buf, pack("ABCXY"));
    end
    pulse(1, 0, 1, 0, 0);
    n_vec++;
    if (bus.letter_valid !== 1'b1 || bus.curr_letter !== 8'h41 || bus.sel_letter !== 8'h42 ||
        bus.cursor !== 3'd5) begin
      n_err++;
      $display("FAIL send_ignores_btn: valid=%b curr=%h sel=%h cursor=%0d expected 1 41 42 5",
               bus.letter_valid, bus.curr_letter, bus.sel_letter, bus.cursor);
    end
    bus.letter_ready = 1'b1;
    repeat (5) @(negedge clk);
    bus.letter_ready = 1'b0;
    n_vec++;
    if (bus.letter_valid !== 1'b0 || bus.cursor !== 3'd0) begin
      n_err++; $display("FAIL edges_drain: valid=%b cursor=%0d expected 0 0", bus.letter_valid, bus.cursor);
    end
  endtask

  task automatic test_range();
    logic [7:0] exp_up;
    logic [7:0] exp_dn;
`ifdef WORDLE_ENTRY_WRAP_EN
    exp_up = 8'h41;
    exp_dn = 8'h5A;
`else
    exp_up = 8'h5A;
    exp_dn = 8'h41;
`endif
    do_reset();
    pulse(0, 1, 0, 0, 0);
    n_vec++;
    if (bus.sel_letter !== exp_dn) begin
      n_err++; $display("FAIL down_at_A: sel=%h expected %h", bus.sel_letter, exp_dn);
    end
    do_reset();
    repeat (25) pulse(1, 0, 0, 0, 0);
    n_vec++;
    if (bus.sel_letter !== 8'h5A) begin
      n_err++; $display("FAIL up_to_Z: sel=%h expected 5a", bus.sel_letter);
    end
    pulse(1, 0, 0, 0, 0);
    n_vec++;
    if (bus.sel_letter !== exp_up) begin
      n_err++; $display("FAIL up_at_Z: sel=%h expected %h", bus.sel_letter, exp_up);
    end
    pulse(1, 1, 0, 0, 0);
    n_vec++;
    if (bus.sel_letter !== ((exp_up == 8'h41) ? 8'h42 : 8'h5A)) begin
      n_err++; $display("FAIL up_over_down: sel=%h", bus.sel_letter);
    end
  endtask

  task automatic test_reset_mid_stream();
    do_reset();
    enter_word("ROBOT");
    bus.letter_ready = 1'b1;
    pulse(0, 0, 0, 0, 1);
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (bus.letter_valid !== 1'b1 || bus.curr_letter !== 8'h42) begin
      n_err++;
      $display("FAIL pre_abort: valid=%b curr=%h expected 1 42", bus.letter_valid, bus.curr_letter);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (bus.letter_valid !== 1'b0 || bus.last_letter !== 1'b0 || bus.curr_letter !== 8'h20 ||
        bus.sel_letter !== 8'h41 || bus.cursor !== 3'd0 || bus.guess_buf !== ALL_SP) begin
      n_err++;
      $display("FAIL abort_reset: valid=%b last=%b curr=%h sel=%h cursor=%0d buf=%h",
               bus.letter_valid, bus.last_letter, bus.curr_letter, bus.sel_letter,
               bus.cursor, bus.guess_buf);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      n_vec++;
      if (bus.letter_valid !== 1'b0) begin
        n_err++; $display("FAIL abort_quiet[%0d]: valid=%b expected 0", j, bus.letter_valid);
      end
    end
    bus.letter_ready = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.BtnU = 1'b0; bus.BtnD = 1'b0; bus.BtnL = 1'b0; bus.BtnR = 1'b0; bus.BtnC = 1'b0;
    bus.enable = 1'b1;
    bus.letter_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_select();
    test_stream_ready();
    test_stream_toggle();
    test_edges();
    test_range();
    test_reset_mid_stream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
